// File: rtl/frame_reader.sv
// Frame-buffer reader: streams FRAME_PIXELS pixels from a 1-cycle-latency memory
// onto a valid/ready pixel port with line and frame markers.
package frame_reader_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DONE  = 3'd2,
    S_ERROR = 3'd3
  } state_t;
endpackage

module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 17,
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned H_PIXELS     = 320,
  parameter int unsigned FRAME_PIXELS = 76800
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  ack,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_eol,
  output logic                  pix_eof,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CW = $clog2(FRAME_PIXELS + 1);
  localparam int unsigned XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;

  state_t                state;
  state_t                state_n;

  logic [CW-1:0]         issued;
  logic                  vld_q;
  logic [CW-1:0]         cap_cnt;
  logic [XW-1:0]         cap_col;

  logic                  skid_v;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_eol;
  logic                  skid_eof;

  logic                  xfer;
  logic [1:0]            occ_c;
  logic                  in_eol;
  logic                  in_eof;

  assign xfer   = pix_valid & pix_ready;
  // Buffer occupancy at the end of this cycle, counting the word arriving now.
  assign occ_c  = 2'(pix_valid) + 2'(skid_v) + 2'(vld_q) - 2'(xfer);
  assign in_eol = (cap_col == XW'(H_PIXELS - 1));
  assign in_eof = (cap_cnt == CW'(FRAME_PIXELS - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and read strobe
  always_comb begin
    state_n = state;
    rd_en   = 1'b0;
    rd_addr = '0;
    case (state)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN: begin
        rd_en = (issued < CW'(FRAME_PIXELS)) && (occ_c < 2'd2);
        if (xfer && pix_eof) state_n = S_DONE;
      end
      S_DONE:  if (ack) state_n = S_IDLE;
      S_ERROR: state_n = S_ERROR;
      default: state_n = S_ERROR;
    endcase
    // Show the address being read, else the last one issued.
    if (rd_en) begin
      rd_addr = ADDR_WIDTH'(issued);
    end else if (issued != '0) begin
      rd_addr = ADDR_WIDTH'(issued - CW'(1));
    end
  end

  // Read tracking, capture tagging and the two-entry output buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued    <= '0;
      vld_q     <= 1'b0;
      cap_cnt   <= '0;
      cap_col   <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
      skid_v    <= 1'b0;
      skid_data <= '0;
      skid_eol  <= 1'b0;
      skid_eof  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      busy  <= (state_n == S_RUN);
      done  <= (state_n == S_DONE);
      error <= (state_n == S_ERROR);
      vld_q <= rd_en;

      if (rd_en) issued <= issued + CW'(1);

      if (state == S_IDLE && start) begin
        issued  <= '0;
        cap_cnt <= '0;
        cap_col <= '0;
      end

      if (state == S_RUN) begin
        if (vld_q) begin
          cap_cnt <= cap_cnt + CW'(1);
          cap_col <= in_eol ? '0 : cap_col + XW'(1);
        end
        if (!pix_valid || xfer) begin
          if (skid_v) begin
            pix_valid <= 1'b1;
            pix_data  <= skid_data;
            pix_eol   <= skid_eol;
            pix_eof   <= skid_eof;
            skid_v    <= vld_q;
            if (vld_q) begin
              skid_data <= rd_data;
              skid_eol  <= in_eol;
              skid_eof  <= in_eof;
            end
          end else begin
            pix_valid <= vld_q;
            if (vld_q) begin
              pix_data <= rd_data;
              pix_eol  <= in_eol;
              pix_eof  <= in_eof;
            end
          end
        end else if (vld_q) begin
          // Output is stalled: park the arriving word behind it.
          skid_v    <= 1'b1;
          skid_data <= rd_data;
          skid_eol  <= in_eol;
          skid_eof  <= in_eof;
        end
      end

      if (state_n != S_RUN) begin
        pix_valid <= 1'b0;
        skid_v    <= 1'b0;
        vld_q     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// Self-checking bench for frame_reader with a pixel-sequence reference model.
module tb_frame_reader;
  localparam int AW = 8;
  localparam int DW = 12;
  localparam int HP = 4;
  localparam int FP = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          ack = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic          pix_eol;
  logic          pix_eof;
  logic          busy;
  logic          done;
  logic          error;

  int total = 0;
  int bad = 0;
  int k = 0;
  int m_issue = 0;
  bit m_run = 1'b0;
  bit m_done = 1'b0;
  bit m_done_next = 1'b0;
  bit chk_on = 1'b0;
  bit stalled_prev = 1'b0;
  logic [DW-1:0] h_data;
  logic h_eol, h_eof;

  frame_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .H_PIXELS(HP), .FRAME_PIXELS(FP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_eol(pix_eol), .pix_eof(pix_eof),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Frame-buffer memory: data = address + 0x100, one cycle after the strobe.
  always @(posedge clk) begin
    rd_data <= rd_en ? DW'(12'h100 + 12'(rd_addr)) : DW'($urandom);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the expected frame stream
  always @(negedge clk) begin
    if (!reset) begin
      stalled_prev = 1'b0;
      m_done = 1'b0;
    end else if (chk_on) begin
      m_done = m_done_next;
      chk("busy", int'(busy), int'(m_run));
      chk("done", int'(done), int'(m_done));
      chk("error", int'(error), 0);
      if (!m_run) begin
        chk("rd_en_idle", int'(rd_en), 0);
        chk("valid_idle", int'(pix_valid), 0);
        stalled_prev = 1'b0;
      end else begin
        if (rd_en) begin
          chk("rd_overrun", int'(m_issue < FP), 1);
          chk("rd_addr", int'(rd_addr), m_issue);
          m_issue++;
        end
        if (stalled_prev) begin
          chk("hold_valid", int'(pix_valid), 1);
          chk("hold_data", int'(pix_data), int'(h_data));
          chk("hold_eol", int'(pix_eol), int'(h_eol));
          chk("hold_eof", int'(pix_eof), int'(h_eof));
        end
        if (pix_valid && pix_ready) begin
          chk("pix_data", int'(pix_data), 'h100 + k);
          chk("pix_eol", int'(pix_eol), int'(k % HP == HP - 1));
          chk("pix_eof", int'(pix_eof), int'(k == FP - 1));
          k++;
          if (k == FP) begin
            m_run = 1'b0;
            m_done_next = 1'b1;
          end
        end
        chk("outstanding", int'(m_issue - k <= 2), 1);
        stalled_prev = pix_valid && !pix_ready;
        h_data = pix_data;
        h_eol  = pix_eol;
        h_eof  = pix_eof;
      end
    end
  end

  task automatic pulse_start(input bit with_ack);
    @(posedge clk); #1 start = 1'b1; ack = with_ack;
    @(posedge clk); #1 start = 1'b0; ack = 1'b0;
    k = 0;
    m_issue = 0;
    m_run = 1'b1;
  endtask

  task automatic do_ack();
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    m_done_next = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, input int budget);
    int n = 0;
    bit got = 1'b0;
    while (n < budget && !got) begin
      @(posedge clk); #1;
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      got = done;
      n++;
    end
    chk("done_reached", int'(got), 1);
    chk("frame_len", k, FP);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_pix_data"}, int'(pix_data), 0);
    chk({tag, "_pix_valid"}, int'(pix_valid), 0);
    chk({tag, "_pix_eol"}, int'(pix_eol), 0);
    chk({tag, "_pix_eof"}, int'(pix_eof), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_error"}, int'(error), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk); reset = 1'b1;
    chk_on = 1'b1;

    // Full-rate frame with hand-computed timing and values
    pix_ready = 1'b1;
    pulse_start(1'b0);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      chk("lat_valid", int'(pix_valid), int'(i >= 2 && i <= 17));
      if (i == 2) chk("first_pix", int'(pix_data), 'h100);
      if (i == 5) chk("eol_pix", int'({pix_data, pix_eol}), int'({12'h103, 1'b1}));
      if (i == 17) chk("eof_pix", int'({pix_data, pix_eol, pix_eof}), int'({12'h10F, 2'b11}));
      if (i == 18) chk("done_lit", int'(done), 1);
    end

    // Hold in done without ack; start must be ignored
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 start = (i == 4);
    end
    @(negedge clk);
    chk("done_held", int'(done), 1);
    do_ack();
    @(negedge clk);
    chk("acked_idle", int'(done), 0);

    // Second frame, started with start and ack together, random backpressure
    pulse_start(1'b1);
    wait_done(1'b1, 400);
    pix_ready = 1'b1;
    do_ack();

    // Sink stalled from the start
    pix_ready = 1'b0;
    pulse_start(1'b0);
    repeat (20) @(negedge clk);
    chk("stall_reads", m_issue, 2);
    chk("stall_addr", int'(rd_addr), 1);
    chk("stall_data", int'(pix_data), 'h100);
    chk("stall_valid", int'(pix_valid), 1);
    @(posedge clk); #1 pix_ready = 1'b1;
    wait_done(1'b0, 60);
    do_ack();

    // Reset mid-frame after seven transfers
    pulse_start(1'b0);
    for (int n = 0; n < 50 && k < 7; n++) @(negedge clk);
    chk("seven_xfers", k, 7);
    @(posedge clk); #2 reset = 1'b0;
    #1 chk_all_zero("midreset");
    m_run = 1'b0;
    m_done_next = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    pulse_start(1'b0);
    repeat (3) @(negedge clk);
    chk("restart_pix", int'(pix_data), 'h100);
    wait_done(1'b0, 60);
    do_ack();

    // Illegal state encoding is trapped and sticky
    chk_on = 1'b0;
    @(negedge clk); #1 force dut.state = frame_reader_pkg::state_t'(3'd6);
    @(posedge clk); #1 release dut.state;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("err_sticky", int'({error, busy, done, pix_valid, rd_en}), int'(5'b10000));
      #1 start = (i % 3 == 0);
      ack = (i % 2 == 0);
    end
    start = 1'b0;
    ack = 1'b0;
    #2 reset = 1'b0;
    #1 chk("err_cleared", int'(error), 0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
